// File: rtl/fetch_unit.sv
// Single-cycle-latency instruction fetch stage with a one-entry skid buffer and redirect.
// Optional macro FETCH_MISALIGN_TRAP_EN adds a sticky fetch_misaligned flag for unaligned redirects.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned ADDR_SIZE = 32'd7
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic        fetch_misaligned
`endif
);

  localparam logic [32:0] ADDR_MASK = (33'd1 << (ADDR_SIZE + 1)) - 33'd1;

  logic [31:0] pc_req;
  logic [31:0] resp_pc;
  logic        resp_live;
  logic        skid_full;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic [31:0] redir_tgt;
  logic        blocked;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misal;

  assign redir_tgt        = redirect_pc;
  assign blocked          = misal;
  assign fetch_misaligned = misal;

  always_ff @(posedge clk) begin
    if (rst) begin
      misal <= 1'b0;
    end else if (redirect_valid) begin
      misal <= (redirect_pc[1:0] != 2'b00);
    end
  end
`else
  logic unused_redir_lo;

  assign redir_tgt       = {redirect_pc[31:2], 2'b00};
  assign blocked         = 1'b0;
  assign unused_redir_lo = ^redirect_pc[1:0];
`endif

  assign imem_addr = {2'b00, pc_req[31:2]} & ADDR_MASK[31:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_req    <= RESET_PC;
      resp_pc   <= 32'd0;
      resp_live <= 1'b0;
      skid_full <= 1'b0;
      skid_inst <= 32'd0;
      skid_pc   <= 32'd0;
    end else if (redirect_valid) begin
      pc_req    <= redir_tgt;
      resp_live <= 1'b0;
      skid_full <= 1'b0;
    end else if (blocked) begin
      resp_live <= 1'b0;
    end else if (!(skid_full && !out_ready)) begin
      if (!skid_full && resp_live && !out_ready) begin
        // Park the response; the address stays put so it can be reissued on drain.
        skid_inst <= imem_inst;
        skid_pc   <= resp_pc;
        skid_full <= 1'b1;
        resp_live <= 1'b0;
      end else begin
        skid_full <= 1'b0;
        resp_pc   <= pc_req;
        resp_live <= 1'b1;
        pc_req    <= pc_req + 32'd4;
      end
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_inst  = imem_inst;
    out_pc    = resp_pc;
    if (skid_full) begin
      out_inst = skid_inst;
      out_pc   = skid_pc;
    end
    if (!rst && !redirect_valid) begin
      out_valid = skid_full || resp_live;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall/drain, redirects, reset-in-stall, wrap.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .ADDR_SIZE(32'd7)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  // Registered instruction memory: word i holds 32'hA000_0000 + i.
  always @(posedge clk) imem_inst <= 32'hA000_0000 + {24'd0, imem_addr[7:0]};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_is(input string tag, input logic [31:0] pc, input logic [31:0] inst);
    check({tag, ".valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, ".pc"}, out_pc, pc);
    check({tag, ".inst"}, out_inst, inst);
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    out_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    tick();
    tick();
    check("rst.valid", {31'd0, out_valid}, 32'd0);
    check("rst.addr", imem_addr, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
    check("rst.misal", {31'd0, fetch_misaligned}, 32'd0);
`endif

    // Stream from reset
    rst = 1'b0;
    #1;
    check("post_rst.valid", {31'd0, out_valid}, 32'd0);
    tick();
    out_is("s0", 32'd0, 32'hA000_0000);
    tick();
    out_is("s4", 32'd4, 32'hA000_0001);
    tick();
    out_is("s8", 32'd8, 32'hA000_0002);

    // Stall for 3 cycles at pc 8
    out_ready = 1'b0;
    #1;
    out_is("stall0", 32'd8, 32'hA000_0002);
    tick();
    out_is("stall1", 32'd8, 32'hA000_0002);
    check("stall1.addr", imem_addr, 32'd3);
    tick();
    out_is("stall2", 32'd8, 32'hA000_0002);
    check("stall2.addr", imem_addr, 32'd3);
    out_ready = 1'b1;
    #1;
    out_is("drain", 32'd8, 32'hA000_0002);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!out_valid && waited < 4);
    out_is("after_drain", 32'd12, 32'hA000_0003);
    tick();
    out_is("s10", 32'h10, 32'hA000_0004);

    // Redirect to 0x40 while pc 0x10 valid
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    #1;
    check("redir.valid_now", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("redir.valid_next", {31'd0, out_valid}, 32'd0);
    tick();
    out_is("r40", 32'h40, 32'hA000_0010);
    tick();
    out_is("r44", 32'h44, 32'hA000_0011);

    // Redirect while skid holds pc 0x44
    out_ready = 1'b0;
    tick();
    out_is("skid44", 32'h44, 32'hA000_0011);
    out_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h20;
    #1;
    check("skid_redir.valid_now", {31'd0, out_valid}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("skid_redir.valid_next", {31'd0, out_valid}, 32'd0);
    tick();
    out_is("r20", 32'h20, 32'hA000_0008);

    // Reset during a stall with skid full
    out_ready = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst_stall.valid_now", {31'd0, out_valid}, 32'd0);
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_stall.valid_next", {31'd0, out_valid}, 32'd0);
    tick();
    out_is("rst_stall.restart", 32'd0, 32'hA000_0000);

    // Unaligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    tick();
`ifdef FETCH_MISALIGN_TRAP_EN
    check("misal.flag", {31'd0, fetch_misaligned}, 32'd1);
    check("misal.valid0", {31'd0, out_valid}, 32'd0);
    tick();
    check("misal.valid1", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    tick();
    check("misal.cleared", {31'd0, fetch_misaligned}, 32'd0);
    out_is("r80", 32'h80, 32'hA000_0020);
`else
    out_is("r42_forced", 32'h40, 32'hA000_0010);
`endif

    // Upper address bits masked off
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FF00;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("mask.addr", imem_addr, 32'h0000_00C0);

    // PC wraps modulo 2^32
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap.addr", imem_addr, 32'h0000_00FF);
    tick();
    out_is("wrap.top", 32'hFFFF_FFFC, 32'hA000_00FF);
    tick();
    out_is("wrap.zero", 32'h0000_0000, 32'hA000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
